// File: rtl/fsm_1_dec.sv
// fsm_1_dec: decode-side framing FSM.
// Pops tagged words from a first-word-fall-through FIFO and rebuilds each
// {data, index, wstrb} triple. A finished triple is pushed into three raw
// output FIFOs at once. Framing errors are flagged and the FSM resyncs on them.
// Decoded triples and framing errors are both counted.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   enc_data_in         FIFO head word {tag[1:0], payload[DATA_W-1:0]}
//   enc_fifo_empty      head word is not valid while high
//   enc_fifo_pop        consumes the head word this cycle (combinational)
//   raw_out_fifo_full   OR of the three output-FIFO full flags
//   raw_*_out           assembled triple, driven from the capture registers
//   raw_out_push        pushes all three output FIFOs (combinational)
//   raw_out_fifo_clr    one-cycle clear of the output FIFOs after reset
//   frame_err           one-cycle pulse for every discarded word
//   triple_cnt          pushed triples, wraps
//   frame_err_cnt       frame_err pulses, saturates
//
// state | meaning
// INIT  | pulse raw_out_fifo_clr, no pops
// DEC_0 | waiting for the data word (tag 0)
// DEC_1 | data held, waiting for the index word (tag 1)
// DEC_2 | data and index held, waiting for the wstrb word (tag 2)
// PUSH  | triple complete, push once the output FIFOs have room
module fsm_1_dec #(
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 16,
    parameter int WSTRB_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W+1:0]   enc_data_in,
    input  logic                enc_fifo_empty,
    output logic                enc_fifo_pop,
    input  logic                raw_out_fifo_full,
    output logic [DATA_W-1:0]   raw_data_out,
    output logic [INDEX_W-1:0]  raw_index_out,
    output logic [WSTRB_W-1:0]  raw_wstrb_out,
    output logic                raw_out_push,
    output logic                raw_out_fifo_clr,
    output logic                frame_err,
    output logic [CNT_W-1:0]    triple_cnt,
    output logic [CNT_W-1:0]    frame_err_cnt
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        DEC_0 = 3'd1,
        DEC_1 = 3'd2,
        DEC_2 = 3'd3,
        PUSH  = 3'd4
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   data_q;
    logic [INDEX_W-1:0]  index_q;
    logic [WSTRB_W-1:0]  wstrb_q;

    logic [1:0]          tag;
    logic [DATA_W-1:0]   payload;
    logic                decoding;
    logic [1:0]          exp_tag;
    logic                err_now;

    assign tag     = enc_data_in[DATA_W+1:DATA_W];
    assign payload = enc_data_in[DATA_W-1:0];

    assign decoding     = (state == DEC_0) || (state == DEC_1) || (state == DEC_2);
    assign enc_fifo_pop = !enc_fifo_empty && decoding;

    // Gated by reset so a triple waiting in PUSH is dropped, not pushed, in the reset cycle.
    assign raw_out_push = (state == PUSH) && !raw_out_fifo_full && !reset;

    assign raw_data_out  = data_q;
    assign raw_index_out = index_q;
    assign raw_wstrb_out = wstrb_q;

    // A popped word whose tag does not match the current slot is a framing error.
    // The word is dropped, or it restarts the triple if its tag is 0.
    always_comb begin
        exp_tag = 2'd0;
        case (state)
            DEC_1:   exp_tag = 2'd1;
            DEC_2:   exp_tag = 2'd2;
            default: exp_tag = 2'd0;
        endcase
        err_now = enc_fifo_pop && (tag != exp_tag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= INIT;
            data_q           <= '0;
            index_q          <= '0;
            wstrb_q          <= '0;
            raw_out_fifo_clr <= 1'b0;
            frame_err        <= 1'b0;
            triple_cnt       <= '0;
            frame_err_cnt    <= '0;
        end else begin
            raw_out_fifo_clr <= 1'b0;
            frame_err        <= err_now;

            if (err_now && (frame_err_cnt != {CNT_W{1'b1}})) begin
                frame_err_cnt <= frame_err_cnt + CNT_W'(1);
            end
            if (raw_out_push) begin
                triple_cnt <= triple_cnt + CNT_W'(1);
            end

            case (state)
                INIT: begin
                    raw_out_fifo_clr <= 1'b1;
                    state            <= DEC_0;
                end
                DEC_0: begin
                    if (enc_fifo_pop && (tag == 2'd0)) begin
                        data_q <= payload;
                        state  <= DEC_1;
                    end
                end
                DEC_1: begin
                    if (enc_fifo_pop) begin
                        if (tag == 2'd1) begin
                            index_q <= payload[INDEX_W-1:0];
                            state   <= DEC_2;
                        end else if (tag == 2'd0) begin
                            data_q <= payload;
                        end else begin
                            state <= DEC_0;
                        end
                    end
                end
                DEC_2: begin
                    if (enc_fifo_pop) begin
                        if (tag == 2'd2) begin
                            wstrb_q <= payload[WSTRB_W-1:0];
                            state   <= PUSH;
                        end else if (tag == 2'd0) begin
                            data_q <= payload;
                            state  <= DEC_1;
                        end else begin
                            state <= DEC_0;
                        end
                    end
                end
                PUSH: begin
                    if (!raw_out_fifo_full) begin
                        state <= DEC_0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_1_dec.sv
module tb_fsm_1_dec;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int SW = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW+1:0]   enc_data_in = '0;
    logic            enc_fifo_empty = 1'b1;
    logic            enc_fifo_pop;
    logic            raw_out_fifo_full = 1'b0;
    logic [DW-1:0]   raw_data_out;
    logic [IW-1:0]   raw_index_out;
    logic [SW-1:0]   raw_wstrb_out;
    logic            raw_out_push;
    logic            raw_out_fifo_clr;
    logic            frame_err;
    logic [CW-1:0]   triple_cnt;
    logic [CW-1:0]   frame_err_cnt;

    fsm_1_dec #(.DATA_W(DW), .INDEX_W(IW), .WSTRB_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .enc_data_in(enc_data_in), .enc_fifo_empty(enc_fifo_empty), .enc_fifo_pop(enc_fifo_pop),
        .raw_out_fifo_full(raw_out_fifo_full),
        .raw_data_out(raw_data_out), .raw_index_out(raw_index_out), .raw_wstrb_out(raw_wstrb_out),
        .raw_out_push(raw_out_push), .raw_out_fifo_clr(raw_out_fifo_clr),
        .frame_err(frame_err), .triple_cnt(triple_cnt), .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
        logic [SW-1:0] w;
    } trip_t;

    int total = 0;
    int bad = 0;

    logic [DW+1:0] encq[$];
    trip_t         expq[$];

    // reference model: how many fields of the current triple are held
    int            k = 0;
    logic [DW-1:0] pd = '0;
    logic [IW-1:0] pi = '0;
    int            exp_err = 0;
    int            exp_trip = 0;

    logic rst_drv = 1'b1;
    logic gate = 1'b0;
    logic full_drv = 1'b0;
    logic last_pop = 1'b0;
    int   clr_seen = 0;
    int   err_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] tag, input logic [DW-1:0] payload);
        encq.push_back({tag, payload});
        if (int'(tag) == k) begin
            if (k == 0) pd = payload;
            else if (k == 1) pi = payload[IW-1:0];
            else begin
                expq.push_back({pd, pi, payload[SW-1:0]});
                exp_trip++;
            end
            k = (k + 1) % 3;
        end else begin
            if (exp_err < 65535) exp_err++;
            if (tag == 2'd0) begin
                pd = payload;
                k = 1;
            end else begin
                k = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (last_pop) encq.delete(0);
        reset = rst_drv;
        raw_out_fifo_full = full_drv;
        enc_fifo_empty = (encq.size() == 0) || gate;
        enc_data_in = (encq.size() != 0) ? encq[0] : '0;
        #1;
        last_pop = enc_fifo_pop;
    endtask

    task automatic drain();
        int n;
        n = 0;
        gate = 1'b0;
        full_drv = 1'b0;
        while ((encq.size() != 0 || expq.size() != 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_left", 64'(encq.size() + expq.size()), 0);
        step();
        step();
        step();
    endtask

    // monitor: samples away from the clock edge and checks pushes against the scoreboard
    always begin
        trip_t e;
        @(negedge clk);
        #2;
        if (raw_out_fifo_clr) clr_seen++;
        if (frame_err) err_seen++;
        if (raw_out_push) begin
            chk("push_while_full", raw_out_fifo_full, 0);
            chk("push_with_err", frame_err, 0);
            if (expq.size() == 0) begin
                chk("unexpected_push", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("push_data", raw_data_out, e.d);
                chk("push_index", raw_index_out, e.i);
                chk("push_wstrb", raw_wstrb_out, e.w);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pa [5];
        int err0;
        logic [DW-1:0] d_hold;

        // reset
        step();
        step();
        chk("rst_push", raw_out_push, 0);
        chk("rst_clr", raw_out_fifo_clr, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_data", raw_data_out, 0);
        chk("rst_tcnt", triple_cnt, 0);
        chk("rst_ecnt", frame_err_cnt, 0);
        rst_drv = 1'b0;
        clr_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_pop", enc_fifo_pop, 0);
            chk("idle_push", raw_out_push, 0);
        end
        chk("clr_cycles", clr_seen, 1);
        chk("idle_index", raw_index_out, 0);

        // back-to-back triple
        send(2'd0, 32'hDEADBEEF);
        send(2'd1, 32'h0000_1234);
        send(2'd2, 32'h0000_000F);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_pop", enc_fifo_pop, 1);
            chk("b2b_nopush", raw_out_push, 0);
        end
        step();
        chk("b2b_push", raw_out_push, 1);
        chk("b2b_pop4", enc_fifo_pop, 0);
        chk("b2b_data", raw_data_out, 32'hDEADBEEF);
        chk("b2b_index", raw_index_out, 16'h1234);
        chk("b2b_wstrb", raw_wstrb_out, 4'hF);
        step();
        chk("b2b_tcnt", triple_cnt, 1);

        // stall in PUSH while full; a following word waits in the FIFO
        full_drv = 1'b1;
        send(2'd0, 32'hCAFE_0001);
        send(2'd1, 32'hFFFF_00AA);
        send(2'd2, 32'hFFFF_FFF5);
        send(2'd0, 32'h1111_2222);
        send(2'd1, 32'h0000_3333);
        send(2'd2, 32'h0000_0004);
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_push", raw_out_push, 0);
            chk("stall_pop", enc_fifo_pop, 0);
            chk("stall_data", raw_data_out, 32'hCAFE_0001);
            chk("stall_index", raw_index_out, 16'h00AA);
            chk("stall_wstrb", raw_wstrb_out, 4'h5);
        end
        full_drv = 1'b0;
        step();
        chk("stall_release", raw_out_push, 1);
        drain();
        chk("stall_tcnt", triple_cnt, 16'(exp_trip));

        // resync: tags 1,0,0,1,2
        err0 = err_seen;
        for (int i = 0; i < 5; i++) pa[i] = $urandom;
        send(2'd1, pa[0]);
        send(2'd0, pa[1]);
        send(2'd0, pa[2]);
        send(2'd1, pa[3]);
        send(2'd2, pa[4]);
        drain();
        chk("resync_pulses", err_seen - err0, 2);
        chk("resync_ecnt", frame_err_cnt, 16'(exp_err));
        chk("resync_tcnt", triple_cnt, 16'(exp_trip));

        // empty toggling every cycle
        err0 = err_seen;
        send(2'd0, $urandom);
        send(2'd1, $urandom);
        send(2'd2, $urandom);
        for (int n = 0; n < 40 && (encq.size() != 0 || expq.size() != 0); n++) begin
            gate = ~gate;
            step();
            if (gate) chk("gated_pop", enc_fifo_pop, 0);
        end
        drain();
        chk("toggle_noerr", err_seen - err0, 0);
        chk("toggle_tcnt", triple_cnt, 16'(exp_trip));

        // reset in DEC_2 after two captures
        send(2'd0, 32'h5555_AAAA);
        send(2'd1, 32'h0000_7777);
        drain();
        rst_drv = 1'b1;
        step();
        chk("rst2_push", raw_out_push, 0);
        step();
        rst_drv = 1'b0;
        k = 0;
        exp_err = 0;
        exp_trip = 0;
        clr_seen = 0;
        for (int i = 0; i < 4; i++) step();
        chk("rst2_clr", clr_seen, 1);
        chk("rst2_tcnt", triple_cnt, 0);
        chk("rst2_ecnt", frame_err_cnt, 0);
        chk("rst2_data", raw_data_out, 0);
        send(2'd0, 32'h0BAD_F00D);
        send(2'd1, 32'h0000_4321);
        send(2'd2, 32'h0000_0009);
        drain();
        chk("rst2_after_tcnt", triple_cnt, 1);
        chk("rst2_after_ecnt", frame_err_cnt, 0);

        // randomized stream with random empty gaps and full back-pressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) send(2'(k), $urandom);
            else send(2'($urandom_range(0, 3)), $urandom);
            gate = ($urandom_range(0, 3) == 0);
            full_drv = ($urandom_range(0, 2) == 0);
            step();
        end
        drain();
        chk("rand_tcnt", triple_cnt, 16'(exp_trip));
        chk("rand_ecnt", frame_err_cnt, 16'(exp_err));
        chk("rand_pulses_vs_cnt", err_seen >= exp_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fsm_1_dec.md
Name: fsm_1_dec

Overview:
- Decode-side control FSM plus datapath for the framed stream produced by the encoder FSM.
- Pops tagged encoded words from a first-word-fall-through FIFO and reassembles each {data, index, wstrb} triple.
- Pushes the complete triple in parallel into three raw output FIFOs.
- Detects framing errors, resynchronises on them, and counts decoded triples and errors.

Parameters:
- DATA_W, 32, width of the data payload and of the encoded payload field.
- INDEX_W, 16, width of the index field (INDEX_W <= DATA_W).
- WSTRB_W, 4, width of the write-strobe field (WSTRB_W <= DATA_W).
- CNT_W, 16, width of the triple and error counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enc_data_in  in  DATA_W+2  encoded FIFO head word: [DATA_W+1:DATA_W] = tag (0=data, 1=index, 2=wstrb, 3=illegal), [DATA_W-1:0] = payload.
- enc_fifo_empty  in  1  encoded FIFO empty; enc_data_in is valid only when this is low.
- enc_fifo_pop  out  1  consumes the head word this cycle (combinational).
- raw_out_fifo_full  in  1  OR of the three output-FIFO full flags.
- raw_data_out  out  DATA_W  assembled data (registered).
- raw_index_out  out  INDEX_W  assembled index (registered).
- raw_wstrb_out  out  WSTRB_W  assembled write strobe (registered).
- raw_out_push  out  1  pushes all three output FIFOs together.
- raw_out_fifo_clr  out  1  clears all three output FIFOs.
- frame_err  out  1  one-cycle pulse on every discarded word.
- triple_cnt  out  CNT_W  count of pushed triples, wraps.
- frame_err_cnt  out  CNT_W  count of frame_err pulses, saturates at all-ones.

Behaviour:
- Reset values: state INIT, raw_out_push=0, raw_out_fifo_clr=0, frame_err=0, capture registers and raw_*_out=0, both counters=0.
- Reset takes priority over every other event. Reset in any state discards any partial triple, and no push occurs in the reset cycle.
- States: INIT, DEC_0, DEC_1, DEC_2, PUSH.
- INIT: raw_out_fifo_clr=1 for exactly one cycle, then go to DEC_0. No pop in INIT.
- enc_fifo_pop = !enc_fifo_empty && state in {DEC_0, DEC_1, DEC_2}. No pop in INIT or PUSH. Every popped word is either captured or discarded.
- DEC_0 expects tag 0:
  - Empty: stay.
  - Tag 0: capture payload into the data register, go to DEC_1.
  - Tag 1, 2 or 3: discard, pulse frame_err, stay in DEC_0.
- DEC_1 expects tag 1:
  - Empty: stay.
  - Tag 1: capture payload[INDEX_W-1:0] into the index register, go to DEC_2.
  - Tag 0: resync. Pulse frame_err, capture the word as new data, stay in DEC_1.
  - Tag 2 or 3: pulse frame_err, discard, go to DEC_0.
- DEC_2 expects tag 2:
  - Empty: stay.
  - Tag 2: capture payload[WSTRB_W-1:0] into the wstrb register, go to PUSH.
  - Tag 0: pulse frame_err, capture as new data, go to DEC_1.
  - Tag 1 or 3: pulse frame_err, discard, go to DEC_0.
- Payload bits above INDEX_W/WSTRB_W are ignored.
- PUSH:
  - raw_*_out are driven continuously from the capture registers and are stable from the cycle after the DEC_2 capture.
  - raw_out_full=1: stay in PUSH, raw_out_push=0.
  - raw_out_full=0: raw_out_push=1 (combinational from state and full) for one cycle, triple_cnt increments, go to DEC_0.
- Full rising during DEC_0..DEC_2 does not stall decoding; the stall applies only in PUSH.
- Minimum throughput is 4 cycles per triple: 3 pops plus 1 push.
- frame_err_cnt increments on each frame_err pulse and holds at 2^CNT_W-1.
- triple_cnt wraps from 2^CNT_W-1 to 0.
- frame_err and raw_out_push never assert in the same cycle.

Test Plan:
- Reset held 2 cycles, enc_fifo_empty=1 -> raw_out_fifo_clr high exactly the one cycle after reset falls; state then idles in DEC_0 with enc_fifo_pop=0; all outputs 0.
- Feed words {0,0xDEADBEEF}, {1,0x1234}, {2,0xF} back-to-back with full=0 -> three pops on consecutive cycles; raw_out_push=1 on the 4th cycle with raw_data_out=0xDEADBEEF, raw_index_out=0x1234, raw_wstrb_out=0xF; triple_cnt=1.
- Same triple with raw_out_fifo_full=1 for 3 cycles after the DEC_2 capture -> no pop and no push while full; push on the first cycle full=0; outputs held stable throughout.
- Stream tag sequence 1, 0, 0, 1, 2 with payloads A..E -> frame_err pulses on word A (DEC_0) and word C (resync in DEC_1); pushed triple is data=C, index=D, wstrb=E; frame_err_cnt=2.
- enc_fifo_empty toggled every cycle during a triple -> pops only when empty=0; triple decoded correctly; no frame_err.
- Assert reset while in DEC_2 after two captures -> no push; INIT clr pulse; counters return to 0; next clean triple decodes correctly.
